// File: rtl/dma_burst_writer.sv
// rtl/dma_burst_writer.sv - AXI4 INCR burst write master fed by a stream, multiple bursts outstanding
module dma_burst_writer #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    num_bursts,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [CNT_WIDTH-1:0]    bursts_done,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY
);

    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BURST_BYTES - 1);
    localparam logic [OUT_W-1:0]      MAX_O      = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]      ONE_O      = OUT_W'(1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0]     ONE_B      = BEAT_W'(1);
    localparam logic [CNT_WIDTH-1:0]  ONE_C      = CNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_WIDTH-1:0]  r_num;
    logic                  r_done;
    logic                  r_error;
    logic [CNT_WIDTH-1:0]  r_bursts_done;
    logic [CNT_WIDTH-1:0]  r_aw_issued;
    logic [OUT_W-1:0]      r_outstanding;
    logic [OUT_W-1:0]      r_w_pending;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_awvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wlast_hs;
    logic                  w_b_hs;
    logic                  w_w_active;
    logic [OUT_W-1:0]      w_out_n;
    logic [OUT_W-1:0]      w_pend_n;
    logic [CNT_WIDTH-1:0]  w_aw_issued_n;
    logic [CNT_WIDTH-1:0]  w_bursts_inc;

    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DATA_WIDTH / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;

    // Write data is a zero-latency pass-through, opened only while an AW-accepted burst awaits data
    assign w_w_active    = (r_w_pending != '0);
    assign M_AXI_WDATA   = s_tdata;
    assign M_AXI_WVALID  = w_w_active & s_tvalid;
    assign s_tready      = w_w_active & M_AXI_WREADY;
    assign M_AXI_WLAST   = w_w_active & (r_beat == LAST_BEAT);

    assign M_AXI_BREADY  = (r_state == S_RUN);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign error         = r_error;
    assign bursts_done   = r_bursts_done;

    assign w_aw_hs       = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs        = M_AXI_WVALID & M_AXI_WREADY;
    assign w_wlast_hs    = w_w_hs & M_AXI_WLAST;
    assign w_b_hs        = M_AXI_BVALID & M_AXI_BREADY;
    assign w_bursts_inc  = r_bursts_done + ONE_C;

    // Next-cycle counter values, so AWVALID can be decided with this cycle's handshakes included
    always_comb begin
        w_out_n       = r_outstanding;
        w_pend_n      = r_w_pending;
        w_aw_issued_n = r_aw_issued;
        if (w_aw_hs) begin
            w_aw_issued_n = r_aw_issued + ONE_C;
        end
        if (w_aw_hs && !w_b_hs) begin
            w_out_n = r_outstanding + ONE_O;
        end else if (!w_aw_hs && w_b_hs) begin
            w_out_n = r_outstanding - ONE_O;
        end
        if (w_aw_hs && !w_wlast_hs) begin
            w_pend_n = r_w_pending + ONE_O;
        end else if (!w_aw_hs && w_wlast_hs) begin
            w_pend_n = r_w_pending - ONE_O;
        end
    end

    // Job sequencing: latch request, vet alignment/length, count responses, flag errors
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_num         <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_bursts_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // a start coinciding with the done pulse belongs to the old job and is dropped
                    if (start && !r_done) begin
                        r_base        <= base_addr;
                        r_num         <= num_bursts;
                        r_error       <= 1'b0;
                        r_bursts_done <= '0;
                        r_state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((r_base & ALIGN_MASK) != '0) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_num == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_b_hs) begin
                        r_bursts_done <= w_bursts_inc;
                        if (M_AXI_BRESP != 2'b00) begin
                            r_error <= 1'b1;
                        end
                        if (w_bursts_inc == r_num) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // AW issue, outstanding window and W beat tracking; all cleared while the job is vetted
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_issued   <= '0;
            r_outstanding <= '0;
            r_w_pending   <= '0;
            r_beat        <= '0;
            r_awvalid     <= 1'b0;
            r_awaddr      <= '0;
        end else if (r_state == S_CHECK) begin
            r_aw_issued   <= '0;
            r_outstanding <= '0;
            r_w_pending   <= '0;
            r_beat        <= '0;
            r_awvalid     <= 1'b0;
            r_awaddr      <= r_base;
        end else if (r_state == S_RUN) begin
            r_aw_issued   <= w_aw_issued_n;
            r_outstanding <= w_out_n;
            r_w_pending   <= w_pend_n;
            if (w_w_hs) begin
                r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + ONE_B;
            end
            if (w_aw_hs) begin
                r_awaddr <= r_awaddr + STRIDE;
            end
            // an offered address stays up until the slave takes it
            if (!(r_awvalid && !M_AXI_AWREADY)) begin
                r_awvalid <= (w_aw_issued_n < r_num) && (w_out_n < MAX_O);
            end
        end else begin
            r_awvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_burst_writer.sv
// tb/tb_dma_burst_writer.sv - scoreboard bench for dma_burst_writer
module tb_dma_burst_writer;

    logic        clk;
    logic        ARESET;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_bursts;
    logic        busy, done, error;
    logic [15:0] bursts_done;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;

    logic        start1, busy1, done1, error1;
    logic [15:0] bursts_done1;
    logic [63:0] s_tdata1;
    logic        s_tvalid1, s_tready1;
    logic [31:0] awaddr1;
    logic [7:0]  awlen1;
    logic [2:0]  awsize1;
    logic [1:0]  awburst1;
    logic        awvalid1, awready1;
    logic [63:0] wdata1;
    logic [7:0]  wstrb1;
    logic        wlast1, wvalid1, wready1;
    logic [1:0]  bresp1;
    logic        bvalid1, bready1;

    dma_burst_writer dut (
        .ACLK(clk), .ARESET(ARESET), .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
        .busy(busy), .done(done), .error(error), .bursts_done(bursts_done),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    dma_burst_writer #(.DATA_WIDTH(64), .BURST_LEN(8)) dut64 (
        .ACLK(clk), .ARESET(ARESET), .start(start1), .base_addr(32'h3000_0000), .num_bursts(16'd3),
        .busy(busy1), .done(done1), .error(error1), .bursts_done(bursts_done1),
        .s_tdata(s_tdata1), .s_tvalid(s_tvalid1), .s_tready(s_tready1),
        .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1), .M_AXI_AWSIZE(awsize1),
        .M_AXI_AWBURST(awburst1), .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(awready1),
        .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WLAST(wlast1),
        .M_AXI_WVALID(wvalid1), .M_AXI_WREADY(wready1),
        .M_AXI_BRESP(bresp1), .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_wd[$];
    bit          exp_wl[$];
    bit          exp_de[$];
    logic [15:0] exp_db[$];
    logic [31:0] src_q[$];
    int          bq[$];

    bit  rand_mode = 0;
    int  b_delay = 0, err_idx = -1, b_count = 0, cyc = 0;
    int  out_model = 0, aw_cnt_job = 0, aw_before_b = 0;
    bit  first_b_seen = 0;
    bit  last_err = 0;
    int  d1_aw = 0, d1_bpend = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=unexpected required=none", name);
    endtask

    initial clk = 0;
    always #5 clk = ~clk;

    // Stream source and AXI slave for the 32-bit DUT: decide at negedge, drive just after posedge
    initial begin : driver
        bit hs_s, hs_wl, hs_b;
        logic [31:0] t32;
        int ti;
        s_tvalid = 0; s_tdata = 0; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        forever begin
            @(negedge clk);
            hs_s  = s_tvalid && s_tready;
            hs_wl = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
            hs_b  = M_AXI_BVALID && M_AXI_BREADY;
            @(posedge clk); #1;
            cyc++;
            if (hs_s && src_q.size() > 0) t32 = src_q.pop_front();
            if (hs_wl) bq.push_back(cyc);
            if (hs_b && bq.size() > 0) begin ti = bq.pop_front(); b_count++; end
            if (!(s_tvalid && !hs_s))
                s_tvalid = (src_q.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
            s_tdata = (src_q.size() > 0) ? src_q[0] : 32'h0;
            M_AXI_AWREADY = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            M_AXI_WREADY  = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            M_AXI_BVALID  = 0;
            if (bq.size() > 0) M_AXI_BVALID = (cyc >= bq[0] + b_delay);
            M_AXI_BRESP = (b_count == err_idx) ? 2'b10 : 2'b00;
        end
    end

    // Always-ready slave and free-running source for the 64-bit DUT
    initial begin : driver64
        bit wl1, b1;
        s_tvalid1 = 1; s_tdata1 = 64'h0; awready1 = 1; wready1 = 1; bvalid1 = 0; bresp1 = 2'b00;
        forever begin
            @(negedge clk);
            wl1 = wvalid1 && wready1 && wlast1;
            b1  = bvalid1 && bready1;
            @(posedge clk); #1;
            d1_bpend = d1_bpend + (wl1 ? 1 : 0) - (b1 ? 1 : 0);
            bvalid1  = (d1_bpend > 0);
            s_tdata1 = s_tdata1 + 64'd1;
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT presents a handshake or a done pulse
    initial begin : monitor
        bit prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, err_next = 0;
        logic [31:0] prev_addr = 0, prev_wd = 0, e32;
        bit eb;
        logic [15:0] e16;
        forever begin
            @(negedge clk);
            if (ARESET) begin
                prev_awv = 0; prev_wv = 0; err_next = 0;
                continue;
            end
            if (err_next) chk("error_after_slverr", error, 1);
            err_next = 0;
            if (prev_awv && !prev_awr) begin
                chk("awvalid_hold", M_AXI_AWVALID, 1);
                chk("awaddr_hold", M_AXI_AWADDR, prev_addr);
            end
            if (prev_wv && !prev_wr) begin
                chk("wvalid_hold", M_AXI_WVALID, 1);
                chk("wdata_hold", M_AXI_WDATA, prev_wd);
            end
            if (M_AXI_AWVALID) chk("aw_outstanding_limit", out_model < 4, 1);
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                if (!first_b_seen) begin first_b_seen = 1; aw_before_b = aw_cnt_job; end
                out_model--;
                if (M_AXI_BRESP != 2'b00) err_next = 1;
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_cnt_job++;
                out_model++;
                if (exp_aw.size() == 0) fail_now("aw_unexpected");
                else begin
                    e32 = exp_aw.pop_front();
                    chk("awaddr", M_AXI_AWADDR, e32);
                    chk("awlen", M_AXI_AWLEN, 15);
                    chk("awsize", M_AXI_AWSIZE, 2);
                    chk("awburst", M_AXI_AWBURST, 1);
                end
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                if (exp_wd.size() == 0) fail_now("w_unexpected");
                else begin
                    e32 = exp_wd.pop_front();
                    eb  = exp_wl.pop_front();
                    chk("wdata", M_AXI_WDATA, e32);
                    chk("wlast", M_AXI_WLAST, eb);
                    chk("wstrb", M_AXI_WSTRB, 4'hf);
                end
            end
            if (done) begin
                if (exp_de.size() == 0) fail_now("done_unexpected");
                else begin
                    eb  = exp_de.pop_front();
                    e16 = exp_db.pop_front();
                    chk("done_error", error, eb);
                    chk("done_bursts", bursts_done, e16);
                end
            end
            prev_awv = M_AXI_AWVALID; prev_awr = M_AXI_AWREADY; prev_addr = M_AXI_AWADDR;
            prev_wv  = M_AXI_WVALID;  prev_wr  = M_AXI_WREADY;  prev_wd   = M_AXI_WDATA;
            if (awvalid1 && awready1) begin
                e32 = 32'h3000_0000 + 32'(d1_aw) * 32'h40;
                chk("dut64_awaddr", awaddr1, e32);
                chk("dut64_awsize", awsize1, 3);
                chk("dut64_awlen", awlen1, 7);
                d1_aw++;
            end
        end
    end

    task automatic load_job(input logic [31:0] base, input int n, input logic [31:0] seed);
        for (int k = 0; k < n; k++) exp_aw.push_back(base + 32'(k) * 32'h40);
        for (int i = 0; i < n * 16; i++) begin
            src_q.push_back(seed + 32'(i));
            exp_wd.push_back(seed + 32'(i));
            exp_wl.push_back((i % 16) == 15);
        end
    endtask

    task automatic run_job(input logic [31:0] base, input int n, input bit load, input int eidx,
                           input int bdel, input bit rnd, input bit exp_err, input int exp_lat,
                           input int exp_awb);
        int lat;
        @(posedge clk); #2;
        chk("pre_start_error", error, last_err);
        if (load) load_job(base, n, base ^ 32'h5A5A_0000);
        exp_de.push_back(exp_err);
        exp_db.push_back(load ? 16'(n) : 16'd0);
        b_delay = bdel; err_idx = eidx; rand_mode = rnd; b_count = 0;
        aw_cnt_job = 0; first_b_seen = 0;
        base_addr = base; num_bursts = 16'(n); start = 1;
        @(posedge clk); #2;
        start = 0;
        chk("start_clears_error", error, 0);
        chk("busy_after_start", busy, 1);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 3000);
        chk("done_seen", done, 1);
        if (exp_lat > 0) chk("done_latency", lat, exp_lat);
        if (exp_awb > 0) chk("aw_before_first_b", aw_before_b, exp_awb);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        last_err = exp_err;
        rand_mode = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_wlast", M_AXI_WLAST, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_bursts_done", bursts_done, 0);
    endtask

    initial begin : main
        int lat;
        ARESET = 1; start = 0; start1 = 0; base_addr = 0; num_bursts = 0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs();
        ARESET = 0;

        run_job(32'h1000_0000, 3, 1, -1, 0, 0, 0, 0, 0);
        run_job(32'h1000_0400, 8, 1, -1, 50, 0, 0, 0, 4);
        run_job(32'h1000_0800, 4, 1, 2, 0, 0, 1, 0, 0);
        run_job(32'h1000_1000, 2, 1, -1, 0, 0, 0, 0, 0);
        run_job(32'h1000_0004, 2, 0, -1, 0, 0, 1, 2, 0);
        run_job(32'h1000_0000, 0, 0, -1, 0, 0, 0, 2, 0);

        // start held across CHECK and the done cycle must launch only one job
        @(posedge clk); #2;
        exp_de.push_back(0); exp_db.push_back(0);
        base_addr = 32'h1000_0000; num_bursts = 0; start = 1;
        repeat (3) @(posedge clk);
        #2;
        start = 0;
        @(negedge clk);
        chk("held_start_single_job", busy, 0);

        run_job(32'h2000_0000, 4, 1, -1, 3, 1, 0, 0, 0);

        // reset in the middle of a running job
        @(posedge clk); #2;
        load_job(32'h1000_2000, 3, 32'hC0DE_0000);
        base_addr = 32'h1000_2000; num_bursts = 3; start = 1;
        @(posedge clk); #2;
        start = 0;
        repeat (12) @(posedge clk);
        #2;
        chk("busy_before_reset", busy, 1);
        ARESET = 1;
        @(posedge clk); #2;
        ARESET = 0;
        chk_reset_outputs();
        src_q.delete(); exp_aw.delete(); exp_wd.delete(); exp_wl.delete();
        exp_de.delete(); exp_db.delete(); bq.delete();
        out_model = 0; s_tvalid = 0; M_AXI_BVALID = 0; last_err = 0;
        repeat (5) @(negedge clk);
        chk("no_done_after_reset", done, 0);

        // 64-bit, 8-beat instance: 64-byte stride and 8-byte beats
        @(posedge clk); #2;
        d1_aw = 0; start1 = 1;
        @(posedge clk); #2;
        start1 = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done1 && lat < 3000);
        chk("dut64_done_seen", done1, 1);
        chk("dut64_bursts_done", bursts_done1, 3);
        chk("dut64_error", error1, 0);
        chk("dut64_aw_count", d1_aw, 3);

        repeat (5) @(posedge clk);
        chk("aw_leftover", exp_aw.size(), 0);
        chk("w_leftover", exp_wd.size(), 0);
        chk("done_leftover", exp_de.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
